// File: rtl/lt24_layer_compositor.sv
`default_nettype none
// ============================================================================
// lt24_layer_compositor
// ----------------------------------------------------------------------------
// Walks every pixel of an H_RES x V_RES frame, reads an upscaled background
// word, overlays up to N_SPR colour-keyed sprite channels fetched from the
// picture memory, and emits RGB565 pixels on a valid/ready stream.
//
// Ports:
//   clk_clk, reset_reset          clock, synchronous active-high reset
//   frame_start/busy/frame_done   frame control and status
//   cfg_*                         staging sprite register write port
//   bg_*                          background memory s2 port (read only)
//   pic_*                         picture memory s2 port (read only)
//   pix_data/valid/ready/last     pixel output stream
//
// Revision: 1.0  initial release
// ============================================================================
module lt24_layer_compositor #(
  parameter int          H_RES    = 240,
  parameter int          V_RES    = 320,
  parameter int          BG_SHIFT = 2,
  parameter int          BG_AW    = 13,
  parameter int          PIC_AW   = 12,
  parameter int          N_SPR    = 4,
  parameter int          SPR_LOG2 = 4,
  parameter logic [15:0] TRANSP   = 16'hF81F
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic                         frame_start,
  output logic                         busy,
  output logic                         frame_done,
  input  logic                         cfg_write,
  input  logic [2:0]                   cfg_chan,
  input  logic                         cfg_en,
  input  logic [8:0]                   cfg_x,
  input  logic [8:0]                   cfg_y,
  input  logic [PIC_AW-2*SPR_LOG2-1:0] cfg_img,
  output logic [BG_AW-1:0]             bg_address,
  output logic                         bg_chipselect,
  output logic                         bg_clken,
  output logic                         bg_write,
  output logic [15:0]                  bg_writedata,
  output logic [1:0]                   bg_byteenable,
  input  logic [15:0]                  bg_readdata,
  output logic [PIC_AW-1:0]            pic_address,
  output logic                         pic_chipselect,
  output logic                         pic_clken,
  output logic                         pic_write,
  output logic [15:0]                  pic_writedata,
  output logic [1:0]                   pic_byteenable,
  input  logic [15:0]                  pic_readdata,
  output logic [15:0]                  pix_data,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic                         pix_last
);

  localparam int         IMG_W   = PIC_AW - 2*SPR_LOG2;
  localparam int         SPR_SZ  = 1 << SPR_LOG2;
  localparam int         BG_COLS = H_RES >> BG_SHIFT;
  localparam logic [2:0] K_TOP   = 3'(N_SPR - 1);
  localparam logic [8:0] X_LAST  = 9'(H_RES - 1);
  localparam logic [8:0] Y_LAST  = 9'(V_RES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BG   = 3'd1,
    S_SPR  = 3'd2,
    S_CAP  = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      state;
  logic [8:0]  x, y;
  logic [2:0]  k;
  logic [15:0] colour;
  logic        prev_hit;   // channel whose read is returning this cycle hit

  logic             stg_en  [N_SPR];
  logic [8:0]       stg_x   [N_SPR];
  logic [8:0]       stg_y   [N_SPR];
  logic [IMG_W-1:0] stg_img [N_SPR];
  logic             act_en  [N_SPR];
  logic [8:0]       act_x   [N_SPR];
  logic [8:0]       act_y   [N_SPR];
  logic [IMG_W-1:0] act_img [N_SPR];

  // Active registers of the channel currently being examined.
  logic             sel_en;
  logic [8:0]       sel_x, sel_y;
  logic [IMG_W-1:0] sel_img;
  logic             hit;

  always_comb begin
    sel_en  = 1'b0;
    sel_x   = '0;
    sel_y   = '0;
    sel_img = '0;
    for (int i = 0; i < N_SPR; i++) begin
      if (k == 3'(i)) begin
        sel_en  = act_en[i];
        sel_x   = act_x[i];
        sel_y   = act_y[i];
        sel_img = act_img[i];
      end
    end
  end

  // Widened by one bit so sprites near 511 never wrap back onto the frame.
  logic [9:0] x10, y10, sx10, sy10;
  assign x10  = {1'b0, x};
  assign y10  = {1'b0, y};
  assign sx10 = {1'b0, sel_x};
  assign sy10 = {1'b0, sel_y};
  assign hit  = sel_en && (x10 >= sx10) && (x10 < sx10 + 10'(SPR_SZ)) &&
                (y10 >= sy10) && (y10 < sy10 + 10'(SPR_SZ));

  assign bg_chipselect  = (state == S_BG);
  assign bg_address     = (state == S_BG)
                          ? BG_AW'(32'(y >> BG_SHIFT) * 32'(BG_COLS) + 32'(x >> BG_SHIFT))
                          : '0;
  assign pic_chipselect = (state == S_SPR) && hit;
  assign pic_address    = pic_chipselect
                          ? {sel_img, SPR_LOG2'(y - sel_y), SPR_LOG2'(x - sel_x)}
                          : '0;

  assign bg_clken       = 1'b1;
  assign bg_write       = 1'b0;
  assign bg_writedata   = 16'h0000;
  assign bg_byteenable  = 2'b11;
  assign pic_clken      = 1'b1;
  assign pic_write      = 1'b0;
  assign pic_writedata  = 16'h0000;
  assign pic_byteenable = 2'b11;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      k          <= '0;
      colour     <= '0;
      prev_hit   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      pix_last   <= 1'b0;
      for (int i = 0; i < N_SPR; i++) begin
        stg_en[i]  <= 1'b0;
        stg_x[i]   <= '0;
        stg_y[i]   <= '0;
        stg_img[i] <= '0;
        act_en[i]  <= 1'b0;
        act_x[i]   <= '0;
        act_y[i]   <= '0;
        act_img[i] <= '0;
      end
    end else begin
      if (cfg_write) begin
        for (int i = 0; i < N_SPR; i++) begin
          if (cfg_chan == 3'(i)) begin
            stg_en[i]  <= cfg_en;
            stg_x[i]   <= cfg_x;
            stg_y[i]   <= cfg_y;
            stg_img[i] <= cfg_img;
          end
        end
      end

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            // Copies the pre-write staging values, so a coincident
            // cfg_write only lands in the following frame.
            for (int i = 0; i < N_SPR; i++) begin
              act_en[i]  <= stg_en[i];
              act_x[i]   <= stg_x[i];
              act_y[i]   <= stg_y[i];
              act_img[i] <= stg_img[i];
            end
            x     <= '0;
            y     <= '0;
            busy  <= 1'b1;
            state <= S_BG;
          end
        end
        S_BG: begin
          k     <= K_TOP;
          state <= S_SPR;
        end
        S_SPR: begin
          if (k == K_TOP) begin
            colour <= bg_readdata;
          end else if (prev_hit && (pic_readdata != TRANSP)) begin
            colour <= pic_readdata;
          end
          prev_hit <= hit;
          if (k == 3'd0) begin
            state <= S_CAP;
          end else begin
            k <= k - 3'd1;
          end
        end
        S_CAP: begin
          pix_data  <= (prev_hit && (pic_readdata != TRANSP)) ? pic_readdata : colour;
          pix_valid <= 1'b1;
          pix_last  <= (x == X_LAST) && (y == Y_LAST);
          state     <= S_OUT;
        end
        S_OUT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            if (pix_last) begin
              frame_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              if (x == X_LAST) begin
                x <= '0;
                y <= y + 9'd1;
              end else begin
                x <= x + 9'd1;
              end
              state <= S_BG;
            end
          end
        end
        S_DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lt24_layer_compositor.sv
`default_nettype none
// ============================================================================
// tb_lt24_layer_compositor
// ----------------------------------------------------------------------------
// Self-checking bench: reduced 40x24 frame, memory models with one-cycle read
// latency, and a per-pixel reference model evaluated from sprite rectangles.
// Revision: 1.0  initial release
// ============================================================================
module tb_lt24_layer_compositor;

  localparam int          H  = 40;
  localparam int          V  = 24;
  localparam int          NS = 4;
  localparam logic [15:0] TK = 16'hF81F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, frame_start, busy, frame_done;
  logic        cfg_write, cfg_en;
  logic [2:0]  cfg_chan;
  logic [8:0]  cfg_x, cfg_y;
  logic [3:0]  cfg_img;
  logic [12:0] bg_address;
  logic        bg_chipselect, bg_clken, bg_write;
  logic [15:0] bg_writedata, bg_readdata;
  logic [1:0]  bg_byteenable;
  logic [11:0] pic_address;
  logic        pic_chipselect, pic_clken, pic_write;
  logic [15:0] pic_writedata, pic_readdata;
  logic [1:0]  pic_byteenable;
  logic [15:0] pix_data;
  logic        pix_valid, pix_ready, pix_last;

  lt24_layer_compositor #(.H_RES(H), .V_RES(V)) dut (
    .clk_clk(clk), .reset_reset(rst),
    .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
    .cfg_write(cfg_write), .cfg_chan(cfg_chan), .cfg_en(cfg_en),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_img(cfg_img),
    .bg_address(bg_address), .bg_chipselect(bg_chipselect), .bg_clken(bg_clken),
    .bg_write(bg_write), .bg_writedata(bg_writedata), .bg_byteenable(bg_byteenable),
    .bg_readdata(bg_readdata),
    .pic_address(pic_address), .pic_chipselect(pic_chipselect), .pic_clken(pic_clken),
    .pic_write(pic_write), .pic_writedata(pic_writedata), .pic_byteenable(pic_byteenable),
    .pic_readdata(pic_readdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last)
  );

  logic [15:0] bg_mem  [8192];
  logic [15:0] pic_mem [4096];

  always @(posedge clk) begin
    if (bg_chipselect)  bg_readdata  <= bg_mem[bg_address];
    if (pic_chipselect) pic_readdata <= pic_mem[pic_address];
  end

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  int saw802 = 0;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (pic_chipselect === 1'b1 && pic_address === 12'd802) saw802++;
  end

  // Reference sprite state: staging and per-frame active copies.
  int m_stg_en [NS], m_stg_x [NS], m_stg_y [NS], m_stg_img [NS];
  int m_act_en [NS], m_act_x [NS], m_act_y [NS], m_act_img [NS];
  logic [15:0] got [H*V];

  function automatic logic [15:0] exp_pix(input int px, input int py);
    logic [15:0] c, w;
    c = bg_mem[(py / 4) * (H / 4) + px / 4];
    for (int ch = NS - 1; ch >= 0; ch--) begin
      if (m_act_en[ch] != 0 && px >= m_act_x[ch] && px < m_act_x[ch] + 16 &&
          py >= m_act_y[ch] && py < m_act_y[ch] + 16) begin
        w = pic_mem[m_act_img[ch] * 256 + (py - m_act_y[ch]) * 16 + (px - m_act_x[ch])];
        if (w != TK) c = w;
      end
    end
    return c;
  endfunction

  task automatic cfg(input int ch, input int en, input int xx, input int yy, input int img);
    cfg_chan  = 3'(ch);
    cfg_en    = (en != 0);
    cfg_x     = 9'(xx);
    cfg_y     = 9'(yy);
    cfg_img   = 4'(img);
    cfg_write = 1'b1;
    @(negedge clk);
    cfg_write = 1'b0;
    if (ch < NS) begin
      m_stg_en[ch] = en; m_stg_x[ch] = xx; m_stg_y[ch] = yy; m_stg_img[ch] = img;
    end
  endtask

  // Runs one frame from a negedge. Optionally: random ready, a 5-cycle stall
  // on pixel (0,1), a mid-frame cfg_write+frame_start after pixel inject_at,
  // abort (return) when row abort_row is reached, or disable channel
  // start_ch with a cfg_write coinciding with frame_start.
  task automatic run_frame(input int rnd_ready, input int stall01, input int inject_at,
                           input int abort_row, input int start_ch);
    int px, py, n, idx, stall_left, held_v, cyc, done_flag, fd0, aborted;
    logic [15:0] held_d, e;
    logic held_l, rdy, is_last;
    fd0 = fd_cnt;
    frame_start = 1'b1;
    if (start_ch >= 0) begin
      cfg_chan = 3'(start_ch); cfg_en = 1'b0; cfg_x = '0; cfg_y = '0; cfg_img = '0;
      cfg_write = 1'b1;
    end
    for (int i = 0; i < NS; i++) begin
      m_act_en[i] = m_stg_en[i]; m_act_x[i] = m_stg_x[i];
      m_act_y[i] = m_stg_y[i];   m_act_img[i] = m_stg_img[i];
    end
    @(negedge clk);
    frame_start = 1'b0;
    cfg_write   = 1'b0;
    if (start_ch >= 0 && start_ch < NS) begin
      m_stg_en[start_ch] = 0; m_stg_x[start_ch] = 0; m_stg_y[start_ch] = 0; m_stg_img[start_ch] = 0;
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: busy=%b expected 1", busy); end
    n = 1;
    while (pix_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n != 7) begin bad++; $display("FAIL first_pixel_latency: cycles=%0d expected 7", n); end

    px = 0; py = 0; idx = 0; stall_left = (stall01 != 0) ? 5 : 0;
    held_v = 0; cyc = 0; done_flag = 0; aborted = 0;
    held_d = '0; held_l = 1'b0;
    while (done_flag == 0 && aborted == 0 && cyc < 40000) begin
      if (abort_row >= 0 && py == abort_row) begin
        aborted = 1;
      end else begin
        if (pix_valid === 1'b1) begin
          if (held_v != 0) begin
            total++;
            if (pix_data !== held_d || pix_last !== held_l) begin
              bad++;
              $display("FAIL stall_hold(%0d,%0d): data=%h last=%b expected data=%h last=%b",
                       px, py, pix_data, pix_last, held_d, held_l);
            end
          end
          if (px == 0 && py == 1 && stall_left > 0) begin rdy = 1'b0; stall_left--; end
          else if (rnd_ready != 0) rdy = ($urandom_range(0, 3) != 0);
          else rdy = 1'b1;
          pix_ready = rdy;
          if (rdy) begin
            e = exp_pix(px, py);
            is_last = (px == H - 1 && py == V - 1);
            total++;
            if (pix_data !== e || pix_last !== is_last) begin
              bad++;
              $display("FAIL pixel(%0d,%0d): data=%h last=%b expected data=%h last=%b",
                       px, py, pix_data, pix_last, e, is_last);
            end
            got[py * H + px] = pix_data;
            held_v = 0;
            if (is_last) done_flag = 1;
            else if (px == H - 1) begin px = 0; py++; end
            else px++;
            idx++;
            if (idx == inject_at) begin
              cfg_chan = 3'd0; cfg_en = 1'b1; cfg_x = 9'd2; cfg_y = 9'd2; cfg_img = 4'd0;
              cfg_write = 1'b1; frame_start = 1'b1;
              m_stg_en[0] = 1; m_stg_x[0] = 2; m_stg_y[0] = 2; m_stg_img[0] = 0;
            end
          end else begin
            held_v = 1; held_d = pix_data; held_l = pix_last;
          end
        end else begin
          pix_ready = (rnd_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        @(negedge clk);
        cyc++;
        frame_start = 1'b0;
        cfg_write   = 1'b0;
      end
    end
    pix_ready = 1'b1;
    if (aborted == 0) begin
      if (done_flag == 0) begin
        total++; bad++;
        $display("FAIL frame_timeout: pixels=%0d expected %0d", idx, H * V);
      end else begin
        total++;
        if (frame_done !== 1'b1) begin bad++; $display("FAIL frame_done_pulse: frame_done=%b expected 1", frame_done); end
        @(negedge clk);
        total++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
          bad++; $display("FAIL frame_end_state: frame_done=%b busy=%b expected 0 0", frame_done, busy);
        end
        total++;
        if (fd_cnt - fd0 != 1) begin bad++; $display("FAIL frame_done_count: count=%0d expected 1", fd_cnt - fd0); end
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NS; i++) begin
      m_stg_en[i] = 0; m_stg_x[i] = 0; m_stg_y[i] = 0; m_stg_img[i] = 0;
      m_act_en[i] = 0; m_act_x[i] = 0; m_act_y[i] = 0; m_act_img[i] = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, frame_done, pix_valid, pix_last, bg_chipselect, pic_chipselect,
         pix_data, bg_address, pic_address} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b valid=%b last=%b bgcs=%b piccs=%b data=%h bga=%h pica=%h expected all 0",
               busy, frame_done, pix_valid, pix_last, bg_chipselect, pic_chipselect, pix_data, bg_address, pic_address);
    end
    total++;
    if ({bg_clken, bg_write, bg_writedata, bg_byteenable, pic_clken, pic_write, pic_writedata, pic_byteenable}
        !== {1'b1, 1'b0, 16'h0, 2'b11, 1'b1, 1'b0, 16'h0, 2'b11}) begin
      bad++; $display("FAIL mem_constants: bg_clken=%b bg_write=%b pic_clken=%b pic_write=%b expected 1 0 1 0",
                      bg_clken, bg_write, pic_clken, pic_write);
    end
    rst = 1'b0;
    clear_model();
    @(negedge clk);
  endtask

  task automatic test_background();
    run_frame(0, 1, -1, -1, -1);
    total++;
    if (got[9 * H + 5] !== 16'd21) begin bad++; $display("FAIL bg_pixel_5_9: data=%h expected 0015", got[9 * H + 5]); end
    total++;
    if (got[H * V - 1] !== 16'd59) begin bad++; $display("FAIL bg_pixel_last: data=%h expected 003b", got[H * V - 1]); end
  endtask

  task automatic test_sprites();
    int s0;
    for (int i = 0; i < 4096; i++)
      pic_mem[i] = ($urandom_range(0, 7) == 0) ? TK : 16'($urandom);
    for (int i = 0; i < 256; i++) begin
      pic_mem[0 * 256 + i] = 16'h001F;
      pic_mem[3 * 256 + i] = 16'h07E0;
      pic_mem[5 * 256 + i] = 16'hABCD;
    end
    pic_mem[3 * 256 + 2 * 16 + 3] = TK;
    cfg(1, 1, 10, 20, 3);
    cfg(0, 1, 18, 20, 0);
    cfg(2, 1, 35, 0, 5);
    cfg(3, 1, $urandom_range(1, 30), $urandom_range(0, 3), $urandom_range(6, 15));
    cfg(5, 1, 0, 0, 9);
    s0 = saw802;
    run_frame(1, 0, -1, -1, -1);
    total++;
    if (got[22 * H + 20] !== 16'h001F) begin bad++; $display("FAIL overlap_20_22: data=%h expected 001f", got[22 * H + 20]); end
    total++;
    if (got[22 * H + 12] !== 16'h07E0) begin bad++; $display("FAIL ch1_12_22: data=%h expected 07e0", got[22 * H + 12]); end
    total++;
    if (got[22 * H + 13] !== 16'd53) begin bad++; $display("FAIL transparent_13_22: data=%h expected 0035", got[22 * H + 13]); end
    total++;
    if (got[22 * H + 34] !== 16'd58) begin bad++; $display("FAIL past_ch0_34_22: data=%h expected 003a", got[22 * H + 34]); end
    for (int xx = 35; xx < 40; xx++) begin
      total++;
      if (got[xx] !== 16'hABCD) begin bad++; $display("FAIL right_edge_%0d: data=%h expected abcd", xx, got[xx]); end
    end
    total++;
    if (got[H] !== 16'h0000) begin bad++; $display("FAIL no_wrap_0_1: data=%h expected 0000", got[H]); end
    total++;
    if (saw802 - s0 != 1) begin bad++; $display("FAIL pic_address_802: seen=%0d expected 1", saw802 - s0); end
  endtask

  task automatic test_midframe();
    run_frame(1, 0, 200, -1, -1);
    run_frame(0, 0, -1, -1, 1);
    total++;
    if (got[2 * H + 2] !== 16'h001F) begin bad++; $display("FAIL moved_ch0_2_2: data=%h expected 001f", got[2 * H + 2]); end
    total++;
    if (got[22 * H + 12] !== 16'h07E0) begin bad++; $display("FAIL ch1_still_on: data=%h expected 07e0", got[22 * H + 12]); end
  endtask

  task automatic test_reset_midframe();
    int fd0;
    fd0 = fd_cnt;
    run_frame(0, 0, -1, 10, -1);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, frame_done, pix_valid, pix_last, bg_chipselect, pic_chipselect,
         pix_data, bg_address, pic_address} !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: busy=%b done=%b valid=%b data=%h bga=%h pica=%h expected all 0",
               busy, frame_done, pix_valid, pix_data, bg_address, pic_address);
    end
    rst = 1'b0;
    clear_model();
    repeat (20) @(negedge clk);
    total++;
    if (fd_cnt != fd0 || busy !== 1'b0) begin
      bad++; $display("FAIL midreset_no_done: frame_done_pulses=%0d busy=%b expected 0 0", fd_cnt - fd0, busy);
    end
    run_frame(0, 0, -1, -1, -1);
    total++;
    if (got[22 * H + 12] !== 16'd53) begin bad++; $display("FAIL sprites_cleared: data=%h expected 0035", got[22 * H + 12]); end
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; cfg_write = 1'b0; cfg_chan = '0; cfg_en = 1'b0;
    cfg_x = '0; cfg_y = '0; cfg_img = '0; pix_ready = 1'b1;
    for (int i = 0; i < 8192; i++) bg_mem[i] = 16'(i);
    for (int i = 0; i < 4096; i++) pic_mem[i] = 16'h0000;
    @(negedge clk);
    test_reset();
    test_background();
    test_sprites();
    test_midframe();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
